// File: rtl/game_status.sv
// -----------------------------------------------------------------------------
// game_status
//
// Gameplay bookkeeping stage that sits directly upstream of the game control
// FSM. Event strobes from the sprite/collision logic update the pellet, life
// and score counters. Frame ticks pace the death and level-clear animations.
// The block produces the single-cycle fail/finish pulses that the control FSM
// consumes, and it takes the control FSM's restart/replay/isIntro back as
// commands.
//
// Optional feature:
//   GAME_STATUS_EXTRA_LIFE_EN - when defined, one extra life (capped at
//   MAX_LIVES) is awarded the first time the score crosses 10000 within a
//   game. When undefined, none of that logic is built.
//
// Ports:
//   Clk              in   system clock
//   Reset            in   synchronous, active-high reset
//   frame_tick       in   one-cycle pulse per video frame (vsync)
//   restart          in   start a new game (highest priority)
//   replay           in   resume after a lost life
//   isIntro          in   intro screen active; forces IDLE
//   pellet_eaten     in   strobe, normal pellet consumed
//   power_eaten      in   strobe, power pellet consumed
//   ghost_hit        in   strobe, Pacman/ghost overlap
//   ghost_frightened in   qualifies ghost_hit: the ghost is edible
//   fail             out  one-cycle pulse, life lost with lives remaining
//   finish           out  one-cycle pulse, game over or level cleared
//   win              out  sticky, last finish was a level clear
//   frozen           out  death/clear animation running; movers halt
//   lives            out  lives remaining
//   pellets_left     out  pellets remaining
//   score            out  current score (saturating)
// -----------------------------------------------------------------------------
module game_status #(
  parameter int NUM_PELLETS  = 244,
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 5,
  parameter int DEATH_FRAMES = 60,
  parameter int CLEAR_FRAMES = 90,
  parameter int SCORE_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               restart,
  input  logic               replay,
  input  logic               isIntro,
  input  logic               pellet_eaten,
  input  logic               power_eaten,
  input  logic               ghost_hit,
  input  logic               ghost_frightened,
  output logic               fail,
  output logic               finish,
  output logic               win,
  output logic               frozen,
  output logic [2:0]         lives,
  output logic [7:0]         pellets_left,
  output logic [SCORE_W-1:0] score
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int MAX_FRAMES = (DEATH_FRAMES > CLEAR_FRAMES) ? DEATH_FRAMES : CLEAR_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  // One extra bit so the score sum carries out instead of wrapping.
  localparam int PW         = SCORE_W + 1;
  // A misconfigured START_LIVES above the ceiling is clamped on restart.
  localparam int INIT_LIVES = (START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES;

  localparam logic [2:0]         LIVES_INIT  = 3'(INIT_LIVES);
  localparam logic [7:0]         PELLET_INIT = 8'(NUM_PELLETS);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [CNT_W-1:0]   DEATH_LAST  = CNT_W'(DEATH_FRAMES);
  localparam logic [CNT_W-1:0]   CLEAR_LAST  = CNT_W'(CLEAR_FRAMES);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DYING,
    WAIT_REPLAY,
    CLEAR,
    OVER
  } state_e;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic               fail_q,     fail_d;
  logic               finish_q,   finish_d;
  logic               win_q,      win_d;
  logic               frozen_q,   frozen_d;
  logic [2:0]         lives_q,    lives_d;
  logic [7:0]         pellets_q,  pellets_d;
  logic [SCORE_W-1:0] score_q,    score_d;
  logic [1:0]         chain_q,    chain_d;   // frightened-ghost kill chain, 0..3
  logic [CNT_W-1:0]   cnt_q,      cnt_d;     // animation frame counter

  // ---------------------------------------------------------------------------
  // Event arithmetic (only consumed in RUN)
  // ---------------------------------------------------------------------------
  logic [1:0]         eat_cnt;
  logic [7:0]         pellets_after;
  logic               edible_hit;
  logic               lethal_hit;
  logic [1:0]         chain_base;
  logic [1:0]         chain_after;
  logic [PW-1:0]      points;
  logic [PW-1:0]      score_sum;
  logic [SCORE_W-1:0] score_after;
  logic [CNT_W-1:0]   cnt_inc;
  logic [2:0]         lives_dec;

  assign edible_hit = ghost_hit &  ghost_frightened;
  assign lethal_hit = ghost_hit & ~ghost_frightened;
  assign eat_cnt    = {1'b0, pellet_eaten} + {1'b0, power_eaten};

  // Pellet count clamps at zero rather than wrapping.
  assign pellets_after = (pellets_q > {6'b0, eat_cnt}) ? (pellets_q - {6'b0, eat_cnt}) : 8'd0;

  // A power pellet restarts the chain before a same-cycle edible hit is scored.
  assign chain_base  = power_eaten ? 2'd0 : chain_q;
  assign chain_after = !edible_hit        ? chain_base :
                       (chain_base == 2'd3) ? 2'd3 : (chain_base + 2'd1);

  assign points = (pellet_eaten ? PW'(10) : PW'(0))
                + (power_eaten  ? PW'(50) : PW'(0))
                + (edible_hit   ? (PW'(200) << chain_base) : PW'(0));

  // The per-cycle gain is far below 2^SCORE_W, so the carry bit alone flags
  // overflow.
  assign score_sum   = {1'b0, score_q} + points;
  assign score_after = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign lives_dec = (lives_q == 3'd0) ? 3'd0 : (lives_q - 3'd1);

`ifdef GAME_STATUS_EXTRA_LIFE_EN
  // ---------------------------------------------------------------------------
  // Extra life at 10000 points, once per game
  // ---------------------------------------------------------------------------
  localparam logic [SCORE_W-1:0] BONUS_SCORE = SCORE_W'(10000);
  localparam logic [2:0]         LIVES_MAX   = 3'(MAX_LIVES);

  logic       bonus_armed_q, bonus_armed_d;
  logic       bonus_cross;
  logic [2:0] lives_bonus;

  assign bonus_cross = bonus_armed_q && (score_q < BONUS_SCORE) && (score_after >= BONUS_SCORE);
  assign lives_bonus = (lives_q >= LIVES_MAX) ? lives_q : (lives_q + 3'd1);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch;
    // fail/finish default low, which makes them single-cycle pulses.
    state_d   = state_q;
    fail_d    = 1'b0;
    finish_d  = 1'b0;
    win_d     = win_q;
    frozen_d  = frozen_q;
    lives_d   = lives_q;
    pellets_d = pellets_q;
    score_d   = score_q;
    chain_d   = chain_q;
    cnt_d     = cnt_q;
`ifdef GAME_STATUS_EXTRA_LIFE_EN
    bonus_armed_d = bonus_armed_q;
`endif

    if (restart) begin
      // Restart wins over everything, including an animation in progress.
      state_d   = RUN;
      win_d     = 1'b0;
      frozen_d  = 1'b0;
      lives_d   = LIVES_INIT;
      pellets_d = PELLET_INIT;
      score_d   = '0;
      chain_d   = 2'd0;
      cnt_d     = '0;
`ifdef GAME_STATUS_EXTRA_LIFE_EN
      bonus_armed_d = 1'b1;
`endif
    end else if (isIntro) begin
      // Abandon silently: no fail/finish pulse, animation dropped.
      state_d  = IDLE;
      frozen_d = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Values held; event strobes ignored.
        end

        RUN: begin
          pellets_d = pellets_after;
          score_d   = score_after;
          chain_d   = chain_after;
`ifdef GAME_STATUS_EXTRA_LIFE_EN
          if (bonus_cross) begin
            lives_d       = lives_bonus;
            bonus_armed_d = 1'b0;
          end
`endif
          // Eating the last pellet beats a same-cycle lethal hit.
          if (pellets_after == 8'd0) begin
            state_d  = CLEAR;
            frozen_d = 1'b1;
            cnt_d    = '0;
          end else if (lethal_hit) begin
            state_d  = DYING;
            frozen_d = 1'b1;
            cnt_d    = '0;
          end
        end

        DYING: begin
          if (frame_tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEATH_LAST) begin
              lives_d = lives_dec;
              if (lives_dec != 3'd0) begin
                fail_d  = 1'b1;
                state_d = WAIT_REPLAY;
              end else begin
                finish_d = 1'b1;
                win_d    = 1'b0;
                frozen_d = 1'b0;
                state_d  = OVER;
              end
            end
          end
        end

        WAIT_REPLAY: begin
          if (replay) begin
            frozen_d = 1'b0;
            chain_d  = 2'd0;
            state_d  = RUN;
          end
        end

        CLEAR: begin
          if (frame_tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CLEAR_LAST) begin
              finish_d = 1'b1;
              win_d    = 1'b1;
              frozen_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end

        OVER: begin
          frozen_d = 1'b0;
          state_d  = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside
  // the clocked branch and is absent from the sensitivity list.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      fail_q    <= 1'b0;
      finish_q  <= 1'b0;
      win_q     <= 1'b0;
      frozen_q  <= 1'b0;
      lives_q   <= 3'd0;
      pellets_q <= 8'd0;
      score_q   <= '0;
      chain_q   <= 2'd0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      fail_q    <= fail_d;
      finish_q  <= finish_d;
      win_q     <= win_d;
      frozen_q  <= frozen_d;
      lives_q   <= lives_d;
      pellets_q <= pellets_d;
      score_q   <= score_d;
      chain_q   <= chain_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef GAME_STATUS_EXTRA_LIFE_EN
  always_ff @(posedge Clk) begin
    if (Reset) bonus_armed_q <= 1'b0;
    else       bonus_armed_q <= bonus_armed_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign fail         = fail_q;
  assign finish       = finish_q;
  assign win          = win_q;
  assign frozen       = frozen_q;
  assign lives        = lives_q;
  assign pellets_left = pellets_q;
  assign score        = score_q;

endmodule
